// File: rtl/uart_cmd_pkg.sv
// Shared widths, receive-FSM state type and common response codes for the UART command wrapper.
package uart_cmd_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] RESP_ACK = 8'hA5;
    localparam logic [BYTE_W-1:0] RESP_NAK = 8'hEE;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LO = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response path: launches one response byte through the UART transmitter and reports completion
// on the rising edge of tx_done.
module uart_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              send_resp,
    input  logic [BYTE_W-1:0] resp,
    input  logic              tx_done,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    output logic              resp_busy,
    output logic              resp_sent
);

    logic              busy_q, busy_d;
    logic              trmt_q, trmt_d;
    logic              sent_q, sent_d;
    logic              done_q, done_d;
    logic [BYTE_W-1:0] txd_q,  txd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            trmt_q <= 1'b0;
            sent_q <= 1'b0;
            done_q <= 1'b0;
            txd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            trmt_q <= trmt_d;
            sent_q <= sent_d;
            done_q <= done_d;
            txd_q  <= txd_d;
        end
    end

    // Requests arriving while busy are dropped; completion is the first tx_done rise while busy.
    always_comb begin
        busy_d = busy_q;
        trmt_d = 1'b0;
        sent_d = 1'b0;
        txd_d  = txd_q;
        done_d = tx_done;
        if (!busy_q && send_resp) begin
            txd_d  = resp;
            trmt_d = 1'b1;
            busy_d = 1'b1;
        end else if (busy_q && tx_done && !done_q) begin
            sent_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = txd_q;
    assign resp_busy = busy_q;
    assign resp_sent = sent_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 16-bit commands (high byte first) from the UART receiver and wraps the response path.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic              send_resp,
    input  logic [BYTE_W-1:0] resp,
    output logic              resp_busy,
    output logic              resp_sent
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    rx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] hi_q,    hi_d;
    logic [CMD_W-1:0]  cmd_q,   cmd_d;
    logic              rdy_q,   rdy_d;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Every offered byte is consumed immediately; a completing low byte beats a same-cycle clear.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        cmd_d      = cmd_q;
        rdy_d      = rdy_q & ~clr_cmd_rdy;
        clr_rx_rdy = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    hi_d       = rx_data;
                    rdy_d      = 1'b0;
                    state_d    = WAIT_LO;
`ifdef UART_CMD_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    cmd_d      = {hi_q, rx_data};
                    rdy_d      = 1'b1;
                    state_d    = IDLE;
                end
`ifdef UART_CMD_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    hi_d    = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;

    uart_resp_tx u_resp_tx (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_busy (resp_busy),
        .resp_sent (resp_sent)
    );

endmodule
